// File: rtl/phase_cap_pkg.sv
`timescale 1ns/1ps
// phase_cap_pkg: shared FSM states, capture modes and helpers
// for the phase error capture block.
package phase_cap_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_READOUT = 2'd3
  } cap_state_e;

  localparam logic [1:0] MODE_CONT    = 2'd0;
  localparam logic [1:0] MODE_ONESHOT = 2'd1;
  localparam logic [1:0] MODE_TRIG    = 2'd2;

  // Magnitude of a sign-extended error; 32 bits so the most
  // negative code of any error width has a positive magnitude.
  function automatic logic [31:0] abs_err(input logic signed [31:0] e);
    return e[31] ? 32'(-e) : 32'(e);
  endfunction

endpackage

// File: rtl/ref_edge_sync.sv
`timescale 1ns/1ps
// ref_edge_sync: brings an asynchronous reference clock into the
// local domain and emits a one-cycle pulse per rising edge.
module ref_edge_sync
  import phase_cap_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic async_i,
  output logic edge_o
);

  logic [2:0] sync_q;
  logic       edge_q;

  // Two sync flops, one history flop, registered edge pulse.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], async_i};
      edge_q <= sync_q[1] & ~sync_q[2];
    end
  end

  assign edge_o = edge_q;

endmodule

// File: rtl/phase_err_capture.sv
`timescale 1ns/1ps
// phase_err_capture: per-ref-edge snapshots of ADPLL error words plus
// a period timestamp into a circular buffer, streamed out oldest-first.
module phase_err_capture
  import phase_cap_pkg::*;
#(
  parameter int CH       = 1,
  parameter int ERR_W    = 8,
  parameter int DEPTH    = 64,
  parameter int TS_W     = 10,
  parameter int LOCK_TOL = 2,
  parameter int LOCK_CNT = 16,
  parameter int TRIG_TH  = 20
) (
  input  logic                     fpga_clk_i,
  input  logic                     reset_i,
  input  logic                     enable_i,
  input  logic [1:0]               mode_i,
  input  logic                     arm_i,
  input  logic                     ref_clk_i,
  input  logic [CH*ERR_W-1:0]      error_i,
  input  logic                     rd_ready_i,
  output logic                     rd_valid_o,
  output logic [TS_W+CH*ERR_W-1:0] rd_data_o,
  output logic                     rd_last_o,
  output logic                     full_o,
  output logic                     overflow_o,
  output logic [CH-1:0]            locked_o,
  output logic [1:0]               state_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = TS_W + CH*ERR_W;
  localparam int LW = $clog2(LOCK_CNT + 1);

  cap_state_e state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] rem_q, rem_d;
  logic full_q, full_d;
  logic ovf_q, ovf_d;
  logic [TS_W-1:0] ts_q, ts_d;
  logic rd_valid_q, rd_valid_d;
  logic rd_last_q, rd_last_d;
  logic [DW-1:0] rd_data_q;
  logic [LW-1:0] lock_cnt_q [CH];
  logic [LW-1:0] lock_cnt_d [CH];
  logic [CH-1:0] locked_q, locked_d;

  logic ref_edge, edge_en, trig_hit, we, rd_load;
  logic signed [ERR_W-1:0] ech;
  logic [31:0] mag [CH];
  logic [DW-1:0] mem [DEPTH];

  ref_edge_sync u_sync (
    .clk_i   (fpga_clk_i),
    .reset_i (reset_i),
    .async_i (ref_clk_i),
    .edge_o  (ref_edge)
  );

  assign edge_en = ref_edge & enable_i;

  // Per-channel magnitudes feed both the trigger and lock checks.
  always_comb begin
    trig_hit = 1'b0;
    ech      = '0;
    for (int c = 0; c < CH; c++) begin
      ech      = error_i[c*ERR_W +: ERR_W];
      mag[c]   = abs_err(32'(ech));
      trig_hit = trig_hit | (mag[c] > 32'(TRIG_TH));
    end
  end

  // Timestamp restarts at each accepted edge and saturates.
  always_comb begin
    if (edge_en)
      ts_d = TS_W'(1);
    else if (&ts_q)
      ts_d = ts_q;
    else
      ts_d = ts_q + TS_W'(1);
  end

  // Lock detector: run of in-tolerance edges, any miss clears it.
  always_comb begin
    locked_d = locked_q;
    for (int c = 0; c < CH; c++) begin
      lock_cnt_d[c] = lock_cnt_q[c];
      if (edge_en) begin
        if (mag[c] <= 32'(LOCK_TOL)) begin
          if (lock_cnt_q[c] != LW'(LOCK_CNT))
            lock_cnt_d[c] = lock_cnt_q[c] + LW'(1);
          locked_d[c] = (lock_cnt_d[c] == LW'(LOCK_CNT));
        end else begin
          lock_cnt_d[c] = '0;
          locked_d[c]   = 1'b0;
        end
      end
    end
  end

  // Capture/readout FSM with buffer pointer bookkeeping.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rem_d      = rem_q;
    full_d     = full_q;
    ovf_d      = ovf_q;
    rd_valid_d = rd_valid_q;
    rd_last_d  = rd_last_q;
    we         = 1'b0;
    rd_load    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (arm_i) begin
          mode_d   = (mode_i == MODE_CONT || mode_i == MODE_TRIG) ?
                     mode_i : MODE_ONESHOT;
          wr_ptr_d = '0;
          count_d  = '0;
          full_d   = 1'b0;
          ovf_d    = 1'b0;
          state_d  = (mode_i == MODE_TRIG) ? S_ARMED : S_CAPTURE;
        end
      end
      S_ARMED: begin
        if (edge_en && trig_hit) begin
          we      = 1'b1;
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (edge_en) begin
          we = 1'b1;
          if (mode_q != MODE_CONT && count_q == CW'(DEPTH - 1))
            state_d = S_READOUT;
        end
        if (mode_q == MODE_CONT && arm_i)
          state_d = S_READOUT;
      end
      S_READOUT: begin
        if (rd_valid_q && rd_ready_i && rd_last_q) begin
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
          state_d    = S_IDLE;
        end else if (rem_q != '0 && (!rd_valid_q || rd_ready_i)) begin
          rd_load    = 1'b1;
          rd_valid_d = 1'b1;
          rd_last_d  = (rem_q == CW'(1));
          rd_ptr_d   = rd_ptr_q + AW'(1);
          rem_d      = rem_q - CW'(1);
        end else if (rd_valid_q && rd_ready_i) begin
          rd_valid_d = 1'b0;
        end else if (rem_q == '0 && !rd_valid_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (we) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (count_q == CW'(DEPTH))
        ovf_d = 1'b1;
      else
        count_d = count_q + CW'(1);
      if (count_q >= CW'(DEPTH - 1))
        full_d = 1'b1;
    end
    if (state_q != S_READOUT && state_d == S_READOUT) begin
      rd_ptr_d = wr_ptr_d - count_d[AW-1:0];
      rem_d    = count_d;
    end
  end

  // State and control registers.
  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      mode_q     <= MODE_CONT;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rem_q      <= '0;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      ts_q       <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      locked_q   <= '0;
      for (int c = 0; c < CH; c++)
        lock_cnt_q[c] <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rem_q      <= rem_d;
      full_q     <= full_d;
      ovf_q      <= ovf_d;
      ts_q       <= ts_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      locked_q   <= locked_d;
      for (int c = 0; c < CH; c++)
        lock_cnt_q[c] <= lock_cnt_d[c];
    end
  end

  // Buffer write port; contents are not cleared by reset.
  always_ff @(posedge fpga_clk_i) begin
    if (we)
      mem[wr_ptr_q] <= {ts_q, error_i};
  end

  // Buffer read port registered straight into the output word.
  always_ff @(posedge fpga_clk_i) begin
    if (reset_i)
      rd_data_q <= '0;
    else if (rd_load)
      rd_data_q <= mem[rd_ptr_q];
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;
  assign rd_last_o  = rd_last_q;
  assign full_o     = full_q;
  assign overflow_o = ovf_q;
  assign locked_o   = locked_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_phase_err_capture.sv
`timescale 1ns/1ps
// tb_phase_err_capture: directed scenarios for capture modes,
// readout flow control, lock detection and enable gating.
module tb_phase_err_capture;

  localparam int DW = 18;

  logic          fpga_clk;
  logic          reset_i;
  logic          enable_i;
  logic [1:0]    mode_i;
  logic          arm_i;
  logic          ref_clk;
  logic [7:0]    error_i;
  logic          rd_ready_i;
  logic          rd_valid_o;
  logic [DW-1:0] rd_data_o;
  logic          rd_last_o;
  logic          full_o;
  logic          overflow_o;
  logic [0:0]    locked_o;
  logic [1:0]    state_o;

  int checks = 0;
  int passes = 0;
  logic [DW-1:0] got [$];
  int last_cnt;
  int last_idx;

  phase_err_capture #(
    .CH(1), .ERR_W(8), .DEPTH(64), .TS_W(10),
    .LOCK_TOL(2), .LOCK_CNT(16), .TRIG_TH(20)
  ) dut (
    .fpga_clk_i (fpga_clk),
    .reset_i    (reset_i),
    .enable_i   (enable_i),
    .mode_i     (mode_i),
    .arm_i      (arm_i),
    .ref_clk_i  (ref_clk),
    .error_i    (error_i),
    .rd_ready_i (rd_ready_i),
    .rd_valid_o (rd_valid_o),
    .rd_data_o  (rd_data_o),
    .rd_last_o  (rd_last_o),
    .full_o     (full_o),
    .overflow_o (overflow_o),
    .locked_o   (locked_o),
    .state_o    (state_o)
  );

  initial fpga_clk = 1'b0;
  always #1.938 fpga_clk = ~fpga_clk;
  initial ref_clk = 1'b0;
  always #100 ref_clk = ~ref_clk;

  task automatic do_reset();
    @(negedge fpga_clk);
    reset_i = 1'b1;
    repeat (2) @(negedge fpga_clk);
    reset_i = 1'b0;
  endtask

  task automatic arm(input logic [1:0] m);
    @(negedge fpga_clk);
    mode_i = m;
    arm_i  = 1'b1;
    @(negedge fpga_clk);
    arm_i  = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget,
                            output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge fpga_clk);
      if (state_o == s) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic collect(input bit toggle, input int stop_after);
    bit r;
    r = 1'b1;
    got.delete();
    last_cnt = 0;
    last_idx = -1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge fpga_clk);
      r = toggle ? ~r : 1'b1;
      rd_ready_i = r;
      if (rd_valid_o && r) begin
        got.push_back(rd_data_o);
        if (rd_last_o) begin
          last_cnt++;
          last_idx = got.size() - 1;
        end
        if (rd_last_o || got.size() == stop_after) break;
      end
    end
    @(negedge fpga_clk);
    rd_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (state_o !== 2'd0) $display("FAIL reset_state got %0d want 0", state_o);
    else passes++;
    checks++;
    if (rd_valid_o !== 1'b0) $display("FAIL reset_valid got %b want 0", rd_valid_o);
    else passes++;
    checks++;
    if ({full_o, overflow_o, rd_last_o} !== 3'b000)
      $display("FAIL reset_flags got %b want 000", {full_o, overflow_o, rd_last_o});
    else passes++;
    checks++;
    if (locked_o !== 1'b0) $display("FAIL reset_locked got %b want 0", locked_o);
    else passes++;
    checks++;
    if (rd_data_o !== '0) $display("FAIL reset_data got %h want 0", rd_data_o);
    else passes++;
    repeat (2) @(negedge ref_clk);
  endtask

  task automatic test_oneshot();
    bit ok;
    logic [9:0] ts;
    @(negedge ref_clk);
    error_i = 8'd0;
    arm(2'd1);
    checks++;
    if (state_o !== 2'd2) $display("FAIL os_capture got %0d want 2", state_o);
    else passes++;
    for (int k = 1; k < 64; k++) begin
      @(negedge ref_clk);
      error_i = 8'(k);
    end
    wait_state(2'd3, 200, ok);
    checks++;
    if (ok !== 1'b1) $display("FAIL os_readout_timeout got %b want 1", ok);
    else passes++;
    checks++;
    if (full_o !== 1'b1) $display("FAIL os_full got %b want 1", full_o);
    else passes++;
    collect(1'b0, 0);
    checks++;
    if (got.size() !== 64) $display("FAIL os_words got %0d want 64", got.size());
    else passes++;
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i][7:0] !== 8'(i))
        $display("FAIL os_err[%0d] got %0d want %0d", i, got[i][7:0], i);
      else passes++;
      ts = got[i][17:8];
      checks++;
      if (ts !== 10'd51 && ts !== 10'd52)
        $display("FAIL os_ts[%0d] got %0d want 51 or 52", i, ts);
      else passes++;
    end
    checks++;
    if (last_cnt !== 1 || last_idx !== 63)
      $display("FAIL os_last got cnt %0d idx %0d want 1/63", last_cnt, last_idx);
    else passes++;
    checks++;
    if (state_o !== 2'd0) $display("FAIL os_idle got %0d want 0", state_o);
    else passes++;
  endtask

  task automatic test_cont_overflow();
    bit ok;
    @(negedge ref_clk);
    error_i = 8'd1;
    arm(2'd0);
    for (int k = 2; k <= 100; k++) begin
      @(negedge ref_clk);
      error_i = 8'(k);
    end
    @(negedge ref_clk);
    checks++;
    if (overflow_o !== 1'b1) $display("FAIL cont_ovf got %b want 1", overflow_o);
    else passes++;
    checks++;
    if (full_o !== 1'b1) $display("FAIL cont_full got %b want 1", full_o);
    else passes++;
    checks++;
    if (state_o !== 2'd2) $display("FAIL cont_capture got %0d want 2", state_o);
    else passes++;
    arm(2'd1);
    wait_state(2'd3, 10, ok);
    collect(1'b0, 0);
    checks++;
    if (got.size() !== 64) $display("FAIL cont_words got %0d want 64", got.size());
    else passes++;
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i][7:0] !== 8'(37 + i))
        $display("FAIL cont_err[%0d] got %0d want %0d", i, got[i][7:0], 37 + i);
      else passes++;
    end
    checks++;
    if (overflow_o !== 1'b1) $display("FAIL cont_ovf_sticky got %b want 1", overflow_o);
    else passes++;
  endtask

  task automatic test_empty_readout();
    int seen;
    seen = 0;
    @(negedge ref_clk);
    arm(2'd0);
    checks++;
    if (overflow_o !== 1'b0) $display("FAIL empty_ovf_clear got %b want 0", overflow_o);
    else passes++;
    checks++;
    if (full_o !== 1'b0) $display("FAIL empty_full_clear got %b want 0", full_o);
    else passes++;
    arm(2'd0);
    rd_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge fpga_clk);
      if (rd_valid_o) seen++;
    end
    rd_ready_i = 1'b0;
    checks++;
    if (seen !== 0) $display("FAIL empty_words got %0d want 0", seen);
    else passes++;
    checks++;
    if (state_o !== 2'd0) $display("FAIL empty_idle got %0d want 0", state_o);
    else passes++;
  endtask

  task automatic test_trig();
    bit ok;
    @(negedge ref_clk);
    error_i = 8'd5;
    arm(2'd2);
    checks++;
    if (state_o !== 2'd1) $display("FAIL trig_armed got %0d want 1", state_o);
    else passes++;
    repeat (10) @(negedge ref_clk);
    checks++;
    if (state_o !== 2'd1) $display("FAIL trig_small got %0d want 1", state_o);
    else passes++;
    error_i = 8'hEC;
    @(negedge ref_clk);
    checks++;
    if (state_o !== 2'd1) $display("FAIL trig_at_th got %0d want 1", state_o);
    else passes++;
    error_i = 8'hEB;
    @(negedge ref_clk);
    checks++;
    if (state_o !== 2'd2) $display("FAIL trig_fire got %0d want 2", state_o);
    else passes++;
    error_i = 8'd1;
    for (int k = 2; k < 64; k++) begin
      @(negedge ref_clk);
      error_i = 8'(k);
    end
    wait_state(2'd3, 200, ok);
    collect(1'b0, 0);
    checks++;
    if (got.size() !== 64) $display("FAIL trig_words got %0d want 64", got.size());
    else passes++;
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i][7:0] !== (i == 0 ? 8'hEB : 8'(i)))
        $display("FAIL trig_err[%0d] got %h want %h", i, got[i][7:0],
                 (i == 0 ? 8'hEB : 8'(i)));
      else passes++;
    end
    @(negedge ref_clk);
    error_i = 8'h80;
    arm(2'd2);
    @(negedge ref_clk);
    checks++;
    if (state_o !== 2'd2) $display("FAIL trig_min got %0d want 2", state_o);
    else passes++;
    do_reset();
    checks++;
    if (state_o !== 2'd0) $display("FAIL trig_reset got %0d want 0", state_o);
    else passes++;
  endtask

  task automatic test_lock();
    logic [7:0] pat [4];
    pat[0] = 8'd1;
    pat[1] = 8'd2;
    pat[2] = 8'hFE;
    pat[3] = 8'd0;
    @(negedge ref_clk);
    error_i = 8'd1;
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      @(negedge ref_clk);
      if (i == 15) begin
        checks++;
        if (locked_o !== 1'b0) $display("FAIL lock_15 got %b want 0", locked_o);
        else passes++;
      end
      if (i < 16) error_i = pat[i % 4];
    end
    checks++;
    if (locked_o !== 1'b1) $display("FAIL lock_16 got %b want 1", locked_o);
    else passes++;
    error_i = 8'd3;
    @(negedge ref_clk);
    checks++;
    if (locked_o !== 1'b0) $display("FAIL lock_drop got %b want 0", locked_o);
    else passes++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    @(negedge ref_clk);
    error_i = 8'd100;
    arm(2'd3);
    checks++;
    if (state_o !== 2'd2) $display("FAIL bp_capture got %0d want 2", state_o);
    else passes++;
    for (int k = 1; k < 64; k++) begin
      @(negedge ref_clk);
      error_i = 8'(100 - k);
    end
    wait_state(2'd3, 200, ok);
    checks++;
    if (ok !== 1'b1) $display("FAIL bp_readout_timeout got %b want 1", ok);
    else passes++;
    collect(1'b1, 0);
    checks++;
    if (got.size() !== 64) $display("FAIL bp_words got %0d want 64", got.size());
    else passes++;
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i][7:0] !== 8'(100 - i))
        $display("FAIL bp_err[%0d] got %0d want %0d", i, got[i][7:0], 100 - i);
      else passes++;
    end
    checks++;
    if (last_idx !== 63) $display("FAIL bp_last got %0d want 63", last_idx);
    else passes++;
  endtask

  task automatic test_mid_reset();
    bit ok;
    @(negedge ref_clk);
    error_i = 8'd10;
    arm(2'd1);
    for (int k = 1; k < 64; k++) begin
      @(negedge ref_clk);
      error_i = 8'(10 + k);
    end
    wait_state(2'd3, 200, ok);
    collect(1'b0, 5);
    reset_i = 1'b1;
    @(negedge fpga_clk);
    reset_i = 1'b0;
    checks++;
    if (rd_valid_o !== 1'b0) $display("FAIL mr_valid got %b want 0", rd_valid_o);
    else passes++;
    checks++;
    if (state_o !== 2'd0) $display("FAIL mr_state got %0d want 0", state_o);
    else passes++;
    checks++;
    if (full_o !== 1'b0) $display("FAIL mr_full got %b want 0", full_o);
    else passes++;
    checks++;
    if (got.size() !== 5) $display("FAIL mr_words got %0d want 5", got.size());
    else passes++;
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i][7:0] !== 8'(10 + i))
        $display("FAIL mr_err[%0d] got %0d want %0d", i, got[i][7:0], 10 + i);
      else passes++;
    end
  endtask

  task automatic test_enable();
    bit ok;
    logic [9:0] ts;
    @(negedge ref_clk);
    error_i = 8'd1;
    arm(2'd0);
    for (int k = 2; k <= 5; k++) begin
      @(negedge ref_clk);
      error_i = 8'(k);
    end
    @(negedge ref_clk);
    enable_i = 1'b0;
    error_i  = 8'd99;
    repeat (20) @(negedge ref_clk);
    enable_i = 1'b1;
    error_i  = 8'd6;
    @(negedge ref_clk);
    error_i = 8'd7;
    @(negedge ref_clk);
    error_i = 8'd8;
    @(negedge ref_clk);
    checks++;
    if (full_o !== 1'b0 || overflow_o !== 1'b0)
      $display("FAIL en_flags got %b%b want 00", full_o, overflow_o);
    else passes++;
    arm(2'd0);
    wait_state(2'd3, 10, ok);
    collect(1'b0, 0);
    checks++;
    if (got.size() !== 8) $display("FAIL en_words got %0d want 8", got.size());
    else passes++;
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i][7:0] !== 8'(i + 1))
        $display("FAIL en_err[%0d] got %0d want %0d", i, got[i][7:0], i + 1);
      else passes++;
    end
    if (got.size() == 8) begin
      ts = got[5][17:8];
      checks++;
      if (ts !== 10'd1023) $display("FAIL en_ts_sat got %0d want 1023", ts);
      else passes++;
      ts = got[6][17:8];
      checks++;
      if (ts !== 10'd51 && ts !== 10'd52)
        $display("FAIL en_ts_resume got %0d want 51 or 52", ts);
      else passes++;
    end
    checks++;
    if (last_idx !== 7) $display("FAIL en_last got %0d want 7", last_idx);
    else passes++;
  endtask

  initial begin
    reset_i    = 1'b1;
    enable_i   = 1'b1;
    mode_i     = 2'd0;
    arm_i      = 1'b0;
    error_i    = 8'd0;
    rd_ready_i = 1'b0;
    test_reset();
    test_oneshot();
    test_cont_overflow();
    test_empty_readout();
    test_trig();
    test_lock();
    test_back_to_back();
    test_mid_reset();
    test_enable();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
